bloqueio_tentativas: RTL and testbench
======================================

# bloqueio_tentativas

Parametrised brute-force lockout controller for the `operacional` datapath of the door lock. It consumes one verdict per confirmed password attempt (`*`) and decides when the keypad is usable. After each wrong attempt it imposes a short pause; after `MAX_ERROS` consecutive errors it imposes a long lockout whose length escalates on repeated lockouts. It also drives the per-display hyphen mask shown on HEX0..HEX(N-1).

## Interface
Parameters:
- `CICLOS_SEG`, 1000: clk cycles per second.
- `MAX_ERROS`, 5: consecutive wrong attempts that trigger a lockout (≥1).
- `T_ERRO_S`, 1: pause after each non-final error, in seconds (≥1).
- `T_BLOQ_S`, 30: first lockout duration, in seconds (≥1).
- `T_BLOQ_MAX_S`, 120: ceiling for escalated lockouts (≥`T_BLOQ_S`).
- `ESCALONAR`, 1: 1 doubles the lockout on each consecutive lockout; 0 keeps it fixed.
- `N_DISPLAYS`, 6: width of the hyphen mask.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `limpar`  in  1  synchronous clear, e.g. on setup exit. Wins over everything.
- `tentativa_valid`  in  1  one-cycle strobe: an attempt was confirmed.
- `tentativa_ok`  in  1  verdict, sampled only with `tentativa_valid`.
- `teclado_en`  out  1  keypad enable.
- `bloqueado`  out  1  high only in BLOQUEIO.
- `bip`  out  1  one-cycle pulse on each rejected attempt.
- `hifen_mask`  out  N_DISPLAYS  bit i=1: HEXi shows a hyphen.
- `erros`  out  $clog2(MAX_ERROS+1)  consecutive-error count.
- `seg_restantes`  out  $clog2(T_BLOQ_MAX_S+1)  whole seconds left in the current pause or lockout; 0 in LIVRE.

## Operation
- Reset (`rst`=0) gives: state LIVRE, `teclado_en`=1, and `bloqueado`, `bip`, `hifen_mask`, `erros`, `seg_restantes`, lockout level all 0.
- `limpar`=1 has the same effect as reset, applied on the next edge.

States:
- **LIVRE**, attempt with `tentativa_ok`=1:
  - `erros`←0, `hifen_mask`←0, level←0.
  - Remain in LIVRE.
- **LIVRE**, attempt with `tentativa_ok`=0: first `erros`←`erros`+1 (call the new value k) and `bip` pulses, then:
  - If k<MAX_ERROS: go to PAUSA_ERRO. `seg_restantes`←T_ERRO_S. `hifen_mask` bits [min(k,N_DISPLAYS)-1:0] set to 1.
  - If k==MAX_ERROS: go to BLOQUEIO. `seg_restantes`←min(T_BLOQ_S<<level, T_BLOQ_MAX_S), or T_BLOQ_S when ESCALONAR=0. `hifen_mask`←all ones.
- **PAUSA_ERRO / BLOQUEIO**:
  - `tentativa_valid` is ignored: no count change, no `bip`.
  - The prescaler restarts at 0 on entry. Each CICLOS_SEG-th cycle decrements `seg_restantes`.
  - The decrement that reaches 0 also transitions to LIVRE.
- **PAUSA_ERRO→LIVRE**: `erros` and `hifen_mask` are kept.
- **BLOQUEIO→LIVRE**:
  - `erros`←0, `hifen_mask`←0.
  - Level increments, saturating once T_BLOQ_S<<level ≥ T_BLOQ_MAX_S.
- Output flags:
  - `teclado_en` = (state==LIVRE).
  - `bloqueado` = (state==BLOQUEIO).
- Arithmetic rules:
  - Shift and minimum are computed at full width before truncation. No wrap is allowed.
  - `erros` never exceeds MAX_ERROS.

## Timing
- All outputs are registered.
- Attempt strobe at edge t gives new `erros`/`hifen_mask`/`bip`/`teclado_en`=0 visible after edge t. `bip` is high for exactly that one cycle.
- `teclado_en` stays low for exactly T×CICLOS_SEG cycles, where T is the loaded seconds value. It rises on the edge of the final prescaler wrap.
- Reset mid-pause or mid-lockout: outputs take reset values immediately, asynchronously. Level is lost.
- `limpar` coincident with `tentativa_valid`: `limpar` wins and the attempt is dropped.
- Attempt strobe in the same cycle as the exit transition: ignored. The keypad is only enabled on the following cycle.
- MAX_ERROS=1: the first error goes directly to BLOQUEIO. PAUSA_ERRO is never entered.

## Structure
- Package `bloqueio_pkg` holds:
  - `typedef enum logic [1:0] {LIVRE, PAUSA_ERRO, BLOQUEIO} estado_bloq_t`.
  - The function computing the escalated duration.
- Sub-module `gerador_tick_seg`:
  - Parameter CICLOS_SEG; inputs clk, rst, `restart`; output one-cycle `tick`.
  - Its counter is $clog2(CICLOS_SEG) bits and wraps at CICLOS_SEG-1.
- Top level: FSM, seconds down-counter, error counter, level register, mask logic.

## Test plan
All scenarios use CICLOS_SEG=10, defaults otherwise.
1. After reset → `teclado_en`=1, `hifen_mask`=6'b000000, `erros`=0, `seg_restantes`=0.
2. Wrong attempt:
   - `bip` high for 1 cycle, `erros`=1, mask=6'b000001, `teclado_en`=0 for exactly 10 cycles.
   - Repeating through 4 errors → mask=6'b001111, `erros`=4.
3. 5th wrong attempt:
   - `bloqueado`=1, mask=6'b111111, `seg_restantes`=30.
   - Strobes every 20 cycles during lockout → no `bip`, `erros` unchanged.
   - `teclado_en` returns after exactly 300 cycles with `erros`=0 and mask=0.
4. Second lockout series (5 more errors) → `seg_restantes`=60. Third → 120. Fourth → 120 (saturated).
5. Correct attempt after 3 errors → `erros`=0, mask=0, level=0. A following 5-error series loads 30.
6. Mid-lockout:
   - `limpar` → LIVRE next cycle with all outputs at reset values.
   - `rst` low mid-pause → asynchronous return to reset values.
   - `limpar`+`tentativa_valid`(ok=0) together → `erros` stays 0.

Source files
------------

// File: rtl/bloqueio_pkg.sv
// Shared types and helpers for the keypad brute-force lockout controller.
package bloqueio_pkg;

    typedef enum logic [1:0] {LIVRE, PAUSA_ERRO, BLOQUEIO} estado_bloq_t;

    localparam int NIVEL_W = 6;

    // Evaluated at 64 bits so the shift cannot wrap before the ceiling is applied.
    function automatic logic [63:0] duracao_bloq(
        input logic [63:0]        t_bloq,
        input logic [63:0]        t_max,
        input logic [NIVEL_W-1:0] nivel,
        input logic               escalonar
    );
        logic [63:0] d;
        d = escalonar ? (t_bloq << nivel) : t_bloq;
        return (d > t_max) ? t_max : d;
    endfunction

    function automatic logic nivel_saturado(
        input logic [63:0]        t_bloq,
        input logic [63:0]        t_max,
        input logic [NIVEL_W-1:0] nivel
    );
        return (t_bloq << nivel) >= t_max;
    endfunction

endpackage

// File: rtl/gerador_tick_seg.sv
// One-second prescaler: tick pulses on the CICLOS_SEG-th cycle after restart drops.
module gerador_tick_seg #(
    parameter int CICLOS_SEG = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_SEG - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == ULTIMO) cnt_d = '0;
    end

    assign tick = !restart && (cnt_q == ULTIMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bloqueio_tentativas.sv
// Lockout controller: short pause after each wrong attempt, escalating lockout after MAX_ERROS.
module bloqueio_tentativas
    import bloqueio_pkg::*;
#(
    parameter int CICLOS_SEG   = 1000,
    parameter int MAX_ERROS    = 5,
    parameter int T_ERRO_S     = 1,
    parameter int T_BLOQ_S     = 30,
    parameter int T_BLOQ_MAX_S = 120,
    parameter int ESCALONAR    = 1,
    parameter int N_DISPLAYS   = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               limpar,
    input  logic                               tentativa_valid,
    input  logic                               tentativa_ok,
    output logic                               teclado_en,
    output logic                               bloqueado,
    output logic                               bip,
    output logic [N_DISPLAYS-1:0]              hifen_mask,
    output logic [$clog2(MAX_ERROS+1)-1:0]     erros,
    output logic [$clog2(T_BLOQ_MAX_S+1)-1:0]  seg_restantes
);

    localparam int EW = $clog2(MAX_ERROS + 1);
    localparam int SW = $clog2(T_BLOQ_MAX_S + 1);

    estado_bloq_t          estado_q, estado_d;
    logic [EW-1:0]         erros_q, erros_d, k;
    logic [SW-1:0]         seg_q, seg_d;
    logic [NIVEL_W-1:0]    nivel_q, nivel_d;
    logic [N_DISPLAYS-1:0] mask_q, mask_d;
    logic                  bip_q, bip_d;
    logic                  teclado_q, teclado_d;
    logic                  bloq_q, bloq_d;
    logic                  tick;

    gerador_tick_seg #(.CICLOS_SEG(CICLOS_SEG)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart ((estado_q == LIVRE) || limpar),
        .tick    (tick)
    );

    always_comb begin
        estado_d = estado_q;
        erros_d  = erros_q;
        seg_d    = seg_q;
        nivel_d  = nivel_q;
        mask_d   = mask_q;
        bip_d    = 1'b0;
        k        = erros_q + 1'b1;
        if (limpar) begin
            estado_d = LIVRE;
            erros_d  = '0;
            seg_d    = '0;
            nivel_d  = '0;
            mask_d   = '0;
        end else begin
            unique case (estado_q)
                LIVRE: begin
                    if (tentativa_valid && tentativa_ok) begin
                        erros_d = '0;
                        mask_d  = '0;
                        nivel_d = '0;
                    end else if (tentativa_valid) begin
                        bip_d   = 1'b1;
                        erros_d = k;
                        if (k >= EW'(MAX_ERROS)) begin
                            estado_d = BLOQUEIO;
                            seg_d    = SW'(duracao_bloq(64'(T_BLOQ_S), 64'(T_BLOQ_MAX_S),
                                                        nivel_q, ESCALONAR != 0));
                            mask_d   = '1;
                        end else begin
                            estado_d = PAUSA_ERRO;
                            seg_d    = SW'(T_ERRO_S);
                            for (int i = 0; i < N_DISPLAYS; i++) mask_d[i] = (i < int'(k));
                        end
                    end
                end
                PAUSA_ERRO: begin
                    if (tick) begin
                        seg_d = seg_q - 1'b1;
                        if (seg_q <= SW'(1)) begin
                            estado_d = LIVRE;
                            seg_d    = '0;
                        end
                    end
                end
                BLOQUEIO: begin
                    if (tick) begin
                        seg_d = seg_q - 1'b1;
                        if (seg_q <= SW'(1)) begin
                            estado_d = LIVRE;
                            seg_d    = '0;
                            erros_d  = '0;
                            mask_d   = '0;
                            if (!nivel_saturado(64'(T_BLOQ_S), 64'(T_BLOQ_MAX_S), nivel_q))
                                nivel_d = nivel_q + 1'b1;
                        end
                    end
                end
                default: estado_d = LIVRE;
            endcase
        end
        teclado_d = (estado_d == LIVRE);
        bloq_d    = (estado_d == BLOQUEIO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= LIVRE;
            erros_q   <= '0;
            seg_q     <= '0;
            nivel_q   <= '0;
            mask_q    <= '0;
            bip_q     <= 1'b0;
            teclado_q <= 1'b1;
            bloq_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            erros_q   <= erros_d;
            seg_q     <= seg_d;
            nivel_q   <= nivel_d;
            mask_q    <= mask_d;
            bip_q     <= bip_d;
            teclado_q <= teclado_d;
            bloq_q    <= bloq_d;
        end
    end

    assign teclado_en    = teclado_q;
    assign bloqueado     = bloq_q;
    assign bip           = bip_q;
    assign hifen_mask    = mask_q;
    assign erros         = erros_q;
    assign seg_restantes = seg_q;

endmodule

// File: tb/tb_bloqueio_tentativas.sv
// Randomized scenario bench for bloqueio_tentativas with CICLOS_SEG=10.
module tb_bloqueio_tentativas;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst, limpar, tentativa_valid, tentativa_ok;
    logic       teclado_en, bloqueado, bip;
    logic [5:0] hifen_mask;
    logic [2:0] erros;
    logic [6:0] seg_restantes;

    int errors = 0;
    int checks = 0;
    int m_erros = 0;   // consecutive wrong attempts
    int m_bloq  = 0;   // lockouts completed since level was last cleared

    bloqueio_tentativas #(.CICLOS_SEG(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .limpar          (limpar),
        .tentativa_valid (tentativa_valid),
        .tentativa_ok    (tentativa_ok),
        .teclado_en      (teclado_en),
        .bloqueado       (bloqueado),
        .bip             (bip),
        .hifen_mask      (hifen_mask),
        .erros           (erros),
        .seg_restantes   (seg_restantes)
    );

    always #5 clk = ~clk;

    function automatic int exp_dur(input int m);
        int t = 30;
        for (int i = 0; i < m; i++) begin
            t = t * 2;
            if (t > 120) t = 120;
        end
        return t;
    endfunction

    function automatic logic [5:0] exp_mask(input int k);
        logic [5:0] r = '0;
        for (int i = 0; i < k && i < 6; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tentar(input logic ok);
        tentativa_valid = 1'b1;
        tentativa_ok    = ok;
        step();
        tentativa_valid = 1'b0;
        tentativa_ok    = 1'b0;
    endtask

    task automatic esperar_teclado(input int budget, output int n);
        n = 0;
        while (teclado_en !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; limpar = 1'b0; tentativa_valid = 1'b0; tentativa_ok = 1'b0;
        idle(3);
        rst = 1'b1;
        step();
        checks++; if (teclado_en !== 1'b1) begin errors++; $display("FAIL reset_teclado got=%0d exp=1", teclado_en); end
        checks++; if (bloqueado !== 1'b0) begin errors++; $display("FAIL reset_bloqueado got=%0d exp=0", bloqueado); end
        checks++; if (bip !== 1'b0) begin errors++; $display("FAIL reset_bip got=%0d exp=0", bip); end
        checks++; if (hifen_mask !== 6'b0) begin errors++; $display("FAIL reset_mask got=%b exp=000000", hifen_mask); end
        checks++; if (erros !== 3'd0) begin errors++; $display("FAIL reset_erros got=%0d exp=0", erros); end
        checks++; if (seg_restantes !== 7'd0) begin errors++; $display("FAIL reset_seg got=%0d exp=0", seg_restantes); end
        m_erros = 0; m_bloq = 0;
    endtask

    task automatic test_erro_pausa();
        int n;
        for (int k = 1; k <= 4; k++) begin
            idle($urandom_range(0, 3));
            tentar(1'b0);
            m_erros++;
            checks++; if (bip !== 1'b1) begin errors++; $display("FAIL pausa_bip k=%0d got=%0d exp=1", k, bip); end
            checks++; if (erros !== 3'(m_erros)) begin errors++; $display("FAIL pausa_erros got=%0d exp=%0d", erros, m_erros); end
            checks++; if (hifen_mask !== exp_mask(m_erros)) begin errors++; $display("FAIL pausa_mask got=%b exp=%b", hifen_mask, exp_mask(m_erros)); end
            checks++; if (seg_restantes !== 7'd1) begin errors++; $display("FAIL pausa_seg got=%0d exp=1", seg_restantes); end
            checks++; if (teclado_en !== 1'b0 || bloqueado !== 1'b0) begin errors++; $display("FAIL pausa_flags teclado=%0d bloq=%0d exp=0,0", teclado_en, bloqueado); end
            step();
            checks++; if (bip !== 1'b0) begin errors++; $display("FAIL pausa_bip_largura got=%0d exp=0", bip); end
            esperar_teclado(100, n);
            checks++; if (n + 1 != C) begin errors++; $display("FAIL pausa_duracao got=%0d exp=%0d", n + 1, C); end
            checks++; if (erros !== 3'(m_erros) || seg_restantes !== 7'd0) begin errors++; $display("FAIL pausa_saida erros=%0d seg=%0d exp=%0d,0", erros, seg_restantes, m_erros); end
        end
        checks++; if (hifen_mask !== 6'b001111) begin errors++; $display("FAIL pausa_mask4 got=%b exp=001111", hifen_mask); end
    endtask

    task automatic test_bloqueio();
        int n, t;
        logic strobe;
        t = exp_dur(m_bloq);
        tentar(1'b0);
        m_erros++;
        checks++; if (bloqueado !== 1'b1 || bip !== 1'b1) begin errors++; $display("FAIL bloq_entrada bloq=%0d bip=%0d exp=1,1", bloqueado, bip); end
        checks++; if (hifen_mask !== 6'b111111) begin errors++; $display("FAIL bloq_mask got=%b exp=111111", hifen_mask); end
        checks++; if (seg_restantes !== 7'(t)) begin errors++; $display("FAIL bloq_seg got=%0d exp=%0d", seg_restantes, t); end
        checks++; if (erros !== 3'd5) begin errors++; $display("FAIL bloq_erros got=%0d exp=5", erros); end
        n = 0;
        while (teclado_en !== 1'b1 && n < 2000) begin
            strobe = (n % 20 == 19);
            if (strobe) begin
                tentativa_valid = 1'b1;
                tentativa_ok    = 1'($urandom_range(0, 1));
            end
            step();
            tentativa_valid = 1'b0;
            n++;
            if (strobe) begin
                checks++; if (bip !== 1'b0) begin errors++; $display("FAIL bloq_strobe_bip n=%0d got=%0d exp=0", n, bip); end
                checks++; if (erros !== (teclado_en ? 3'd0 : 3'd5)) begin errors++; $display("FAIL bloq_strobe_erros n=%0d got=%0d", n, erros); end
            end
            if (teclado_en === 1'b0) begin
                checks++; if (seg_restantes !== 7'(t - n / C)) begin errors++; $display("FAIL bloq_contagem n=%0d got=%0d exp=%0d", n, seg_restantes, t - n / C); end
            end
        end
        m_erros = 0; m_bloq++;
        checks++; if (n != t * C) begin errors++; $display("FAIL bloq_duracao got=%0d exp=%0d", n, t * C); end
        checks++; if (erros !== 3'd0 || hifen_mask !== 6'b0 || bloqueado !== 1'b0 || seg_restantes !== 7'd0) begin
            errors++; $display("FAIL bloq_saida erros=%0d mask=%b bloq=%0d seg=%0d", erros, hifen_mask, bloqueado, seg_restantes);
        end
        step();
        checks++; if (teclado_en !== 1'b1 || bip !== 1'b0) begin errors++; $display("FAIL bloq_pos_saida teclado=%0d bip=%0d exp=1,0", teclado_en, bip); end
    endtask

    task automatic test_escalonamento();
        int n, t;
        for (int s = 0; s < 3; s++) begin
            for (int k = 1; k < 5; k++) begin
                idle($urandom_range(0, 3));
                tentar(1'b0);
                esperar_teclado(100, n);
                checks++; if (n != C) begin errors++; $display("FAIL esc_pausa got=%0d exp=%0d", n, C); end
            end
            t = exp_dur(m_bloq);
            tentar(1'b0);
            checks++; if (seg_restantes !== 7'(t)) begin errors++; $display("FAIL esc_seg serie=%0d got=%0d exp=%0d", s, seg_restantes, t); end
            esperar_teclado(2000, n);
            checks++; if (n != t * C) begin errors++; $display("FAIL esc_duracao got=%0d exp=%0d", n, t * C); end
            m_bloq++;
        end
    endtask

    task automatic test_acerto();
        int n, kk;
        kk = $urandom_range(1, 4);
        for (int k = 1; k <= kk; k++) begin
            tentar(1'b0);
            esperar_teclado(100, n);
        end
        checks++; if (erros !== 3'(kk) || hifen_mask !== exp_mask(kk)) begin errors++; $display("FAIL acerto_antes erros=%0d mask=%b exp=%0d", erros, hifen_mask, kk); end
        tentar(1'b1);
        m_bloq = 0;
        checks++; if (erros !== 3'd0 || hifen_mask !== 6'b0) begin errors++; $display("FAIL acerto_limpa erros=%0d mask=%b exp=0", erros, hifen_mask); end
        checks++; if (bip !== 1'b0 || teclado_en !== 1'b1) begin errors++; $display("FAIL acerto_flags bip=%0d teclado=%0d exp=0,1", bip, teclado_en); end
        for (int k = 1; k < 5; k++) begin
            tentar(1'b0);
            esperar_teclado(100, n);
        end
        tentar(1'b0);
        checks++; if (seg_restantes !== 7'(exp_dur(m_bloq))) begin errors++; $display("FAIL acerto_nivel got=%0d exp=%0d", seg_restantes, exp_dur(m_bloq)); end
        esperar_teclado(2000, n);
        checks++; if (n != exp_dur(m_bloq) * C) begin errors++; $display("FAIL acerto_duracao got=%0d exp=%0d", n, exp_dur(m_bloq) * C); end
        m_bloq++;
    endtask

    task automatic test_limpar_rst();
        int n;
        for (int k = 1; k < 5; k++) begin
            tentar(1'b0);
            esperar_teclado(100, n);
        end
        tentar(1'b0);
        checks++; if (seg_restantes !== 7'(exp_dur(m_bloq))) begin errors++; $display("FAIL limpar_nivel got=%0d exp=%0d", seg_restantes, exp_dur(m_bloq)); end
        idle($urandom_range(5, 100));
        limpar = 1'b1;
        step();
        limpar = 1'b0;
        m_bloq = 0;
        checks++; if (teclado_en !== 1'b1 || bloqueado !== 1'b0 || bip !== 1'b0) begin errors++; $display("FAIL limpar_flags teclado=%0d bloq=%0d bip=%0d", teclado_en, bloqueado, bip); end
        checks++; if (erros !== 3'd0 || hifen_mask !== 6'b0 || seg_restantes !== 7'd0) begin errors++; $display("FAIL limpar_valores erros=%0d mask=%b seg=%0d", erros, hifen_mask, seg_restantes); end
        for (int k = 1; k < 5; k++) begin
            tentar(1'b0);
            esperar_teclado(100, n);
        end
        tentar(1'b0);
        checks++; if (seg_restantes !== 7'(exp_dur(m_bloq))) begin errors++; $display("FAIL limpar_nivel_perdido got=%0d exp=%0d", seg_restantes, exp_dur(m_bloq)); end
        limpar = 1'b1;
        step();
        limpar = 1'b0;
        tentar(1'b0);
        idle($urandom_range(1, 7));
        #3;
        rst = 1'b0;
        #1;
        checks++; if (teclado_en !== 1'b1 || bloqueado !== 1'b0 || erros !== 3'd0) begin errors++; $display("FAIL rst_async teclado=%0d bloq=%0d erros=%0d", teclado_en, bloqueado, erros); end
        checks++; if (hifen_mask !== 6'b0 || seg_restantes !== 7'd0) begin errors++; $display("FAIL rst_async_valores mask=%b seg=%0d", hifen_mask, seg_restantes); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        limpar = 1'b1; tentativa_valid = 1'b1; tentativa_ok = 1'b0;
        step();
        limpar = 1'b0; tentativa_valid = 1'b0;
        checks++; if (erros !== 3'd0 || bip !== 1'b0 || teclado_en !== 1'b1) begin errors++; $display("FAIL limpar_com_tentativa erros=%0d bip=%0d teclado=%0d", erros, bip, teclado_en); end
    endtask

    initial begin
        test_reset();
        test_erro_pausa();
        test_bloqueio();
        test_escalonamento();
        test_acerto();
        test_limpar_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
